// File: rtl/icache_refill_ctrl_if.sv
// Signal bundle between the icache refill controller, the fetch/tag pipeline and the
// AXI-style read port; master is the controller side, slave is the environment side.
interface icache_refill_ctrl_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        tag_hit;
    logic        tag_valid;
    logic        tag_work;
    logic        busy;
    logic [3:0]  tag_wen;
    logic [20:0] tag_wdata;
    logic [31:0] tag_waddr;
    logic [7:0]  data_wen;
    logic [31:0] data_wdata;
    logic        mem_arvalid;
    logic [31:0] mem_araddr;
    logic [7:0]  mem_arlen;
    logic        mem_arready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_rlast;
    logic        mem_rready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        err;

    modport master (
        input  req_valid, req_addr, tag_hit, tag_valid, tag_work,
        input  mem_arready, mem_rvalid, mem_rdata, mem_rlast,
        output busy, tag_wen, tag_wdata, tag_waddr, data_wen, data_wdata,
        output mem_arvalid, mem_araddr, mem_arlen, mem_rready,
        output resp_valid, resp_data, err
    );

    modport slave (
        output req_valid, req_addr, tag_hit, tag_valid, tag_work,
        output mem_arready, mem_rvalid, mem_rdata, mem_rlast,
        input  busy, tag_wen, tag_wdata, tag_waddr, data_wen, data_wdata,
        input  mem_arvalid, mem_araddr, mem_arlen, mem_rready,
        input  resp_valid, resp_data, err
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Icache miss handler: on a lookup miss it bursts the 32-byte line in over the read
// channel, fills the data RAM word by word, writes the tag and returns the requested word.
module icache_refill_ctrl #(
    parameter int         LINE_WORDS = 8,
    parameter logic [7:0] ARLEN      = 8'd7
) (
    input  logic                        clk,
    input  logic                        rst,
    icache_refill_ctrl_if.master        bus
);
    localparam logic [2:0] LAST_BEAT = 3'(LINE_WORDS - 1);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_TAGW, S_DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] line_addr, line_addr_nxt;
    logic [2:0]  off, off_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic [31:0] resp_q, resp_nxt;
    logic        unused_ok;

    assign unused_ok     = &{1'b0, bus.req_addr[1:0]};
    assign bus.mem_arlen = ARLEN;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values computed by the combinational block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            line_addr <= '0;
            off       <= '0;
            cnt       <= '0;
            resp_q    <= '0;
        end else begin
            state     <= state_nxt;
            line_addr <= line_addr_nxt;
            off       <= off_nxt;
            cnt       <= cnt_nxt;
            resp_q    <= resp_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves a value
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt      = state;
        line_addr_nxt  = line_addr;
        off_nxt        = off;
        cnt_nxt        = cnt;
        resp_nxt       = resp_q;
        bus.busy        = (state != S_IDLE);
        bus.tag_waddr   = (state != S_IDLE) ? line_addr : '0;
        bus.tag_wen     = '0;
        bus.tag_wdata   = '0;
        bus.data_wen    = '0;
        bus.data_wdata  = '0;
        bus.mem_arvalid = 1'b0;
        bus.mem_araddr  = '0;
        bus.mem_rready  = 1'b0;
        bus.resp_valid  = 1'b0;
        bus.resp_data   = '0;
        bus.err         = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.req_valid && bus.tag_work && !(bus.tag_hit && bus.tag_valid)) begin
                    line_addr_nxt = {bus.req_addr[31:5], 5'b0};
                    off_nxt       = bus.req_addr[4:2];
                    state_nxt     = S_AR;
                end
            end
            S_AR: begin
                bus.mem_arvalid = 1'b1;
                bus.mem_araddr  = line_addr;
                if (bus.mem_arready) begin
                    cnt_nxt   = '0;
                    state_nxt = S_R;
                end
            end
            S_R: begin
                bus.mem_rready = 1'b1;
                if (bus.mem_rvalid) begin
                    bus.data_wen   = 8'b1 << cnt;
                    bus.data_wdata = bus.mem_rdata;
                    cnt_nxt        = cnt + 3'd1;
                    if (cnt == off)
                        resp_nxt = bus.mem_rdata;
                    // A burst must end exactly on the last word; any other shape is dropped.
                    if (bus.mem_rlast && cnt == LAST_BEAT) begin
                        state_nxt = S_TAGW;
                    end else if (bus.mem_rlast || cnt == LAST_BEAT) begin
                        bus.err   = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_TAGW: begin
                bus.tag_wen   = 4'hf;
                bus.tag_wdata = {1'b1, line_addr[31:12]};
                state_nxt     = S_DONE;
            end
            S_DONE: begin
                bus.resp_valid = 1'b1;
                bus.resp_data  = resp_q;
                state_nxt      = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl: stimulus pushes expected output events,
// a negedge monitor pops and compares them whenever the DUT presents one.
module tb_icache_refill_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    icache_refill_ctrl_if bus ();

    icache_refill_ctrl #(.LINE_WORDS(8), .ARLEN(8'd7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef enum logic [2:0] {EV_AR, EV_DATA, EV_ERR, EV_TAG, EV_RESP} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [31:0] a;
        logic [31:0] b;
    } ev_t;

    ev_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input ev_kind_t k, input logic [31:0] a, input logic [31:0] b);
        ev_t e;
        e.kind = k;
        e.a    = a;
        e.b    = b;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_kind_t k, input logic [31:0] a, input logic [31:0] b);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected: got event %s a=0x%08h b=0x%08h expected none (t=%0t)",
                     k.name(), a, b, $time);
        end else begin
            e = exp_q.pop_front();
            check("sb_kind", 32'(k), 32'(e.kind));
            check({"sb_", e.kind.name(), ".a"}, a, e.a);
            check({"sb_", e.kind.name(), ".b"}, b, e.b);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_arvalid && bus.mem_arready)
                observe(EV_AR, bus.mem_araddr, {24'b0, bus.mem_arlen});
            if (bus.data_wen != 8'h00)
                observe(EV_DATA, {24'b0, bus.data_wen}, bus.data_wdata);
            if (bus.err)
                observe(EV_ERR, 32'h0, 32'h0);
            if (bus.tag_wen != 4'h0)
                observe(EV_TAG, {11'b0, bus.tag_wdata}, bus.tag_waddr);
            if (bus.resp_valid)
                observe(EV_RESP, bus.resp_data, 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_busy"},       {31'b0, bus.busy},        32'h0);
        check({pfx, "_tag_wen"},    {28'b0, bus.tag_wen},     32'h0);
        check({pfx, "_data_wen"},   {24'b0, bus.data_wen},    32'h0);
        check({pfx, "_arvalid"},    {31'b0, bus.mem_arvalid}, 32'h0);
        check({pfx, "_rready"},     {31'b0, bus.mem_rready},  32'h0);
        check({pfx, "_resp_valid"}, {31'b0, bus.resp_valid},  32'h0);
        check({pfx, "_err"},        {31'b0, bus.err},         32'h0);
        check({pfx, "_tag_wdata"},  {11'b0, bus.tag_wdata},   32'h0);
        check({pfx, "_tag_waddr"},  bus.tag_waddr,            32'h0);
        check({pfx, "_data_wdata"}, bus.data_wdata,           32'h0);
        check({pfx, "_araddr"},     bus.mem_araddr,           32'h0);
        check({pfx, "_resp_data"},  bus.resp_data,            32'h0);
        check({pfx, "_arlen"},      {24'b0, bus.mem_arlen},   32'h7);
    endtask

    // One miss and its refill. Beats carry 0xA0+i. rlast_beat=7 is a well-formed burst,
    // <7 ends early, 8 never asserts rlast. rst_beat>=0 resets on that beat.
    task automatic refill(input logic [31:0] addr, input int ar_delay, input int gap_before,
                          input int rlast_beat, input int rst_beat, input bit poke_busy,
                          output int latency);
        logic [31:0] line;
        int          off, n_beats, miss_cyc;
        bit          bad;
        line     = {addr[31:5], 5'b0};
        off      = int'(addr[4:2]);
        bad      = (rlast_beat != 7);
        latency  = -1;
        n_beats  = (rst_beat >= 0) ? rst_beat : (rlast_beat < 7 ? rlast_beat + 1 : 8);

        push(EV_AR, line, 32'h7);
        for (int i = 0; i < n_beats; i++)
            push(EV_DATA, 32'(1) << i, 32'hA0 + 32'(i));
        if (rst_beat < 0) begin
            if (bad) begin
                push(EV_ERR, 32'h0, 32'h0);
            end else begin
                push(EV_TAG, {12'b0, 1'b1, line[31:12]}, line);
                push(EV_RESP, 32'hA0 + 32'(off), 32'h0);
            end
        end

        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.tag_hit   = 1'b0;
        bus.tag_valid = 1'b0;
        bus.tag_work  = 1'b1;
        miss_cyc      = cyc;
        tick();
        bus.req_valid = 1'b0;
        #1;
        check("arvalid_after_miss", {31'b0, bus.mem_arvalid}, 32'h1);
        check("busy_after_miss",    {31'b0, bus.busy},        32'h1);

        for (int d = 0; d < ar_delay; d++) begin
            if (poke_busy) begin
                bus.req_valid = 1'b1;
                bus.req_addr  = 32'h0BAD_0004;
            end
            tick();
        end
        bus.req_valid   = 1'b0;
        bus.mem_arready = 1'b1;
        tick();
        bus.mem_arready = 1'b0;
        #1;
        check("rready_after_ar", {31'b0, bus.mem_rready}, 32'h1);

        for (int i = 0; i < 8; i++) begin
            if (i == gap_before) begin
                bus.mem_rvalid = 1'b0;
                #1;
                check("gap_data_wen", {24'b0, bus.data_wen}, 32'h0);
                tick();
            end
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 32'hA0 + 32'(i);
            bus.mem_rlast  = (i == rlast_beat);
            if (i == rst_beat) rst = 1'b1;
            tick();
            bus.mem_rvalid = 1'b0;
            bus.mem_rlast  = 1'b0;
            if (i == rst_beat) begin
                #1;
                check_all_zero("mid_rst");
                rst = 1'b0;
                repeat (3) tick();
                return;
            end
            if (bad && (i == rlast_beat || i == 7)) begin
                #1;
                check("err_idle_busy", {31'b0, bus.busy}, 32'h0);
                check("err_single",    {31'b0, bus.err},  32'h0);
                if (rlast_beat == 8) begin
                    // A stray beat after the error must be dropped.
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = 32'hEE;
                    #1;
                    check("stray_rready", {31'b0, bus.mem_rready}, 32'h0);
                    tick();
                    bus.mem_rvalid = 1'b0;
                end
                repeat (2) tick();
                return;
            end
        end

        check("tagw_wen", {28'b0, bus.tag_wen}, 32'hf);
        tick();
        check("done_resp_valid", {31'b0, bus.resp_valid}, 32'h1);
        latency = cyc - miss_cyc;
        tick();
        check("idle_after_done", {31'b0, bus.busy}, 32'h0);
    endtask

    initial begin
        int lat0, lat1, lat2;
        bus.req_valid   = 1'b0;
        bus.req_addr    = '0;
        bus.tag_hit     = 1'b0;
        bus.tag_valid   = 1'b0;
        bus.tag_work    = 1'b0;
        bus.mem_arready = 1'b0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = '0;
        bus.mem_rlast   = 1'b0;

        repeat (2) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Hits never start a refill.
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h1234_5678;
        bus.tag_hit   = 1'b1;
        bus.tag_valid = 1'b1;
        bus.tag_work  = 1'b1;
        repeat (3) begin
            tick();
            check("hit_busy",    {31'b0, bus.busy},        32'h0);
            check("hit_arvalid", {31'b0, bus.mem_arvalid}, 32'h0);
        end
        bus.req_valid = 1'b0;
        tick();

        // Zero-wait refill: miss at N, response at N+11.
        refill(32'h1234_5678, 0, -1, 7, -1, 1'b0, lat0);
        check("latency_zero_wait", 32'(lat0), 32'd11);

        // 3-cycle arready stall plus one rvalid gap; a busy-time request is ignored.
        refill(32'h1234_5678, 3, 2, 7, -1, 1'b1, lat1);
        check("latency_delta", 32'(lat1 - lat0), 32'd4);

        // Early rlast on beat 4, then a burst missing rlast on beat 7.
        refill(32'h0000_1ABC, 0, -1, 4, -1, 1'b0, lat2);
        refill(32'h0000_1ABC, 1, -1, 8, -1, 1'b0, lat2);

        // Reset during beat 3.
        refill(32'h0040_0020, 0, -1, 7, 3, 1'b0, lat2);

        // Miss while the tag array is still sweeping is ignored.
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'hDEAD_BEEC;
        bus.tag_hit   = 1'b0;
        bus.tag_valid = 1'b0;
        bus.tag_work  = 1'b0;
        repeat (3) begin
            tick();
            check("nowork_busy",    {31'b0, bus.busy},        32'h0);
            check("nowork_arvalid", {31'b0, bus.mem_arvalid}, 32'h0);
        end
        refill(32'hDEAD_BEEC, 0, -1, 7, -1, 1'b0, lat2);
        check("latency_after_work", 32'(lat2), 32'd11);

        // Back-to-back miss taken in the IDLE cycle right after DONE.
        refill(32'h0000_0004, 0, -1, 7, -1, 1'b0, lat2);
        check("latency_back_to_back", 32'(lat2), 32'd11);

        repeat (4) tick();
        check("sb_queue_empty", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
